// File: rtl/yfport_pkg.sv
// Shared constants for the yfport I/O responder: opcodes, p2 field layout, reset word.
package yfport_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_PUSH      = 3'd1,
        OP_POP       = 3'd2,
        OP_PEEK      = 3'd3,
        OP_CLEAR     = 3'd4,
        OP_TIMER_LO  = 3'd5,
        OP_TIMER_HI  = 3'd6,
        OP_TIMER_CLR = 3'd7
    } op_e;

    localparam int P2_ACK     = 15;
    localparam int P2_ERR     = 14;
    localparam int P2_FULL    = 13;
    localparam int P2_EMPTY   = 12;
    localparam int P2_CNT_HI  = 11;
    localparam int P2_CNT_LO  = 8;
    localparam int P2_DATA_HI = 7;
    localparam int P2_DATA_LO = 0;

    localparam int CNT_W = 4;

    localparam logic [15:0] P2_RST = 16'h1000;

endpackage

// File: rtl/yfport_fifo.sv
// Byte FIFO for yfport: DEPTH entries, wrapping pointers plus a separate occupancy count.
module yfport_fifo
    import yfport_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [7:0]       wdata,
    output logic [7:0]       head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[head_q];

    // Caller issues at most one of push/pop/clear per cycle; guards make misuse harmless.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (push && !full) begin
            mem_d[tail_q] = wdata;
            tail_d        = tail_q + 1'b1;
            count_d       = count_q + 1'b1;
        end else if (pop && !empty) begin
            head_d  = head_q + 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/yfport.sv
// yfport: toggle-handshake port responder with byte FIFO and cycle timer.
// Timer, snapshot and opcodes 5-7 are built only when YFPORT_TIMER_EN is defined.
module yfport
    import yfport_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] p1,
    output logic [15:0] p2
);

    logic [15:0]      p1_q, p1_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [7:0]       data_q, data_d;
    logic             primed_q, primed_d;
    logic             fifo_push, fifo_pop, fifo_clear;
    logic [7:0]       fifo_head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    op_e              op;
    logic [3:0]       unused_rsvd;

`ifdef YFPORT_TIMER_EN
    logic [15:0] timer_q, timer_d;
    logic [7:0]  snap_q, snap_d;
`endif

    assign op          = op_e'(p1_q[14:12]);
    assign unused_rsvd = p1_q[11:8];

    yfport_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .wdata (p1_q[7:0]),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        p1_d       = p1;
        primed_d   = 1'b1;
        ack_d      = ack_q;
        err_d      = err_q;
        data_d     = data_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;
`ifdef YFPORT_TIMER_EN
        timer_d    = timer_q + 16'd1;
        snap_d     = snap_q;
`endif
        // Priming adopts the toggle level p1_q is about to hold, so a held request bit is not a command.
        if (!primed_q) begin
            ack_d = p1[15];
        end else if (p1_q[15] != ack_q) begin
            ack_d  = p1_q[15];
            err_d  = 1'b0;
            data_d = 8'h00;
            case (op)
                OP_NOP: ;
                OP_PUSH: begin
                    if (fifo_full) err_d = 1'b1;
                    else           fifo_push = 1'b1;
                end
                OP_POP: begin
                    if (fifo_empty) begin
                        err_d = 1'b1;
                    end else begin
                        data_d   = fifo_head;
                        fifo_pop = 1'b1;
                    end
                end
                OP_PEEK: begin
                    if (fifo_empty) err_d  = 1'b1;
                    else            data_d = fifo_head;
                end
                OP_CLEAR: fifo_clear = 1'b1;
`ifdef YFPORT_TIMER_EN
                OP_TIMER_LO: begin
                    data_d = timer_q[7:0];
                    snap_d = timer_q[15:8];
                end
                OP_TIMER_HI: data_d = snap_q;
                OP_TIMER_CLR: begin
                    timer_d = 16'd0;
                    snap_d  = 8'd0;
                end
`else
                OP_TIMER_LO, OP_TIMER_HI, OP_TIMER_CLR: err_d = 1'b1;
`endif
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_q     <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= 8'h00;
            primed_q <= 1'b0;
        end else begin
            p1_q     <= p1_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            data_q   <= data_d;
            primed_q <= primed_d;
        end
    end

`ifdef YFPORT_TIMER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            snap_q  <= '0;
        end else begin
            timer_q <= timer_d;
            snap_q  <= snap_d;
        end
    end
`endif

    // Status fields come straight from the FIFO's own registers, so they track the live state.
    always_comb begin
        p2                           = '0;
        p2[P2_ACK]                   = ack_q;
        p2[P2_ERR]                   = err_q;
        p2[P2_FULL]                  = fifo_full;
        p2[P2_EMPTY]                 = fifo_empty;
        p2[P2_CNT_HI:P2_CNT_LO]      = fifo_count;
        p2[P2_DATA_HI:P2_DATA_LO]    = data_q;
    end

endmodule

// File: tb/tb_yfport.sv
// Directed self-checking bench for yfport; timer checks follow YFPORT_TIMER_EN.
module tb_yfport;
    import yfport_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] p1;
    logic [15:0] p2;
    logic        tgl;
    int          n_tests;
    int          n_fail;
    int          cyc;

    yfport #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .p1  (p1),
        .p2  (p2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_p2(input logic e, input logic f, input logic em,
                                           input logic [3:0] c, input logic [7:0] d);
        return {tgl, e, f, em, c, d};
    endfunction

    // Issue one command and wait (bounded) for the ack; latency must be exactly two cycles.
    task automatic cmd(input logic [2:0] op, input logic [7:0] d, output logic [15:0] rsp);
        int lat;
        tgl = ~tgl;
        p1  = {tgl, op, 4'h0, d};
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (p2[15] != tgl && lat < 10);
        chk("latency", 16'(lat), 16'd2);
        rsp = p2;
    endtask

    logic [15:0] r;
    logic [7:0]  pat [8];
    int          t0, t1, tval, texp;
    logic [7:0]  tlo, thi;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pat = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

        // Reset with request bit held high
        rst = 1'b1;
        p1  = 16'h8000;
        tgl = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_p2", p2, 16'h1000);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("primed_p2", p2, 16'h9000);

        // Push three, peek
        cmd(OP_PUSH, 8'h11, r);
        cmd(OP_PUSH, 8'h22, r);
        cmd(OP_PUSH, 8'h33, r);
        chk("push3", r, exp_p2(1'b0, 1'b0, 1'b0, 4'd3, 8'h00));
        cmd(OP_PEEK, 8'h00, r);
        chk("peek", r, exp_p2(1'b0, 1'b0, 1'b0, 4'd3, 8'h11));

        // Pop three in order, then underflow
        cmd(OP_POP, 8'h00, r);
        chk("pop1", r, exp_p2(1'b0, 1'b0, 1'b0, 4'd2, 8'h11));
        cmd(OP_POP, 8'h00, r);
        chk("pop2", r, exp_p2(1'b0, 1'b0, 1'b0, 4'd1, 8'h22));
        cmd(OP_POP, 8'h00, r);
        chk("pop3", r, exp_p2(1'b0, 1'b0, 1'b1, 4'd0, 8'h33));
        cmd(OP_POP, 8'h00, r);
        chk("pop_empty", r, exp_p2(1'b1, 1'b0, 1'b1, 4'd0, 8'h00));
        cmd(OP_PEEK, 8'h00, r);
        chk("peek_empty", r, exp_p2(1'b1, 1'b0, 1'b1, 4'd0, 8'h00));
        cmd(OP_NOP, 8'h5C, r);
        chk("nop_clears_err", r, exp_p2(1'b0, 1'b0, 1'b1, 4'd0, 8'h00));

        // Fill (pointers start at 3, so this wraps), overflow, drain
        for (int i = 0; i < 8; i++) begin
            cmd(OP_PUSH, pat[i], r);
            chk("fill", r, exp_p2(1'b0, i == 7, 1'b0, 4'(i + 1), 8'h00));
        end
        cmd(OP_PUSH, 8'hAA, r);
        chk("overflow", r, exp_p2(1'b1, 1'b1, 1'b0, 4'd8, 8'h00));
        for (int i = 0; i < 8; i++) begin
            cmd(OP_POP, 8'h00, r);
            chk("drain", r, exp_p2(1'b0, 1'b0, i == 7, 4'(7 - i), pat[i]));
        end

        // Clear
        cmd(OP_PUSH, 8'h9A, r);
        cmd(OP_PUSH, 8'h9B, r);
        cmd(OP_CLEAR, 8'h00, r);
        chk("clear", r, exp_p2(1'b0, 1'b0, 1'b1, 4'd0, 8'h00));

        // Timer
`ifdef YFPORT_TIMER_EN
        cmd(OP_TIMER_CLR, 8'h00, r);
        chk("timer_clr", r, exp_p2(1'b0, 1'b0, 1'b1, 4'd0, 8'h00));
        t0 = cyc;
        repeat (300) @(negedge clk);
        cmd(OP_TIMER_LO, 8'h00, r);
        t1  = cyc;
        tlo = r[7:0];
        chk("timer_lo_err", {15'd0, r[14]}, 16'd0);
        repeat (20) @(negedge clk);
        cmd(OP_TIMER_HI, 8'h00, r);
        thi = r[7:0];
        chk("timer_hi_err", {15'd0, r[14]}, 16'd0);
        tval = int'({thi, tlo});
        texp = t1 - t0 - 1;
        if (!(tval >= texp - 2 && tval <= texp + 2))
            $display("timer value %0d, expected near %0d", tval, texp);
        chk("timer_near", 16'(tval >= texp - 2 && tval <= texp + 2), 16'd1);
`else
        cmd(OP_TIMER_LO, 8'h00, r);
        chk("timer_lo_off", r, exp_p2(1'b1, 1'b0, 1'b1, 4'd0, 8'h00));
        cmd(OP_TIMER_HI, 8'h00, r);
        chk("timer_hi_off", r, exp_p2(1'b1, 1'b0, 1'b1, 4'd0, 8'h00));
        cmd(OP_TIMER_CLR, 8'h00, r);
        chk("timer_clr_off", r, exp_p2(1'b1, 1'b0, 1'b1, 4'd0, 8'h00));
`endif

        // Reset mid-handshake after five pushes
        for (int i = 0; i < 5; i++) cmd(OP_PUSH, 8'(8'h41 + i), r);
        chk("push5", r, exp_p2(1'b0, 1'b0, 1'b0, 4'd5, 8'h00));
        tgl = ~tgl;
        p1  = {tgl, OP_PUSH, 4'h0, 8'h77};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_p2", p2, 16'h1000);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("after_reset", p2, exp_p2(1'b0, 1'b0, 1'b1, 4'd0, 8'h00));
        cmd(OP_PUSH, 8'h5A, r);
        chk("first_push", r, exp_p2(1'b0, 1'b0, 1'b0, 4'd1, 8'h00));
        cmd(OP_PEEK, 8'h00, r);
        chk("first_peek", r, exp_p2(1'b0, 1'b0, 1'b0, 4'd1, 8'h5A));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
